// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter.
// Line levels are named so the FSM output logic reads in protocol terms.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

    localparam int   UART_DATA_BITS = 8;
    localparam logic LINE_IDLE      = 1'b1;
    localparam logic LINE_START     = 1'b0;
    localparam logic LINE_STOP      = 1'b1;

endpackage

// File: rtl/uart_transmitter_baud_tick.sv
// Bit-period counter: one-cycle tick on the last cycle of each serial bit.
// Latency: tick on count CLKS_PER_BIT-1; no backpressure, counts while en is high.
// Held at zero while disabled or cleared so every frame starts on a bit boundary.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 68
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int                CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = en && (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = cnt_q;
        if (clear || !en) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter (optional even parity bit with UART_TX_PARITY_EN).
// Latency: tx falls on the accepting edge; frame lasts 10 (11) bit periods.
// Backpressure: tx_start is ignored while tx_busy; requests are not queued.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 68
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    uart_tx_state_t state_q, state_d;
    logic [2:0]     idx_q, idx_d;
    logic [7:0]     shift_q, shift_d;
    logic           tx_q, tx_d;
    logic           done_q, done_d;
    logic           accept;
    logic           bit_tick;

    assign accept = (state_q == IDLE) && tx_start;

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (accept),
        .en    (state_q != IDLE),
        .tick  (bit_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= LINE_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: begin
                if (tx_start) begin
                    state_d = START;
                    shift_d = tx_data;
                    idx_d   = '0;
                end
            end
            START: begin
                if (bit_tick) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (idx_q == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_tick) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_tick) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level is derived from the next state so tx changes on the same edge as the state.
    always_comb begin
        tx_d   = LINE_IDLE;
        done_d = (state_q == STOP) && bit_tick;
        case (state_d)
            IDLE:    tx_d = LINE_IDLE;
            START:   tx_d = LINE_START;
            DATA:    tx_d = shift_d[idx_d];
            PARITY:  tx_d = ^shift_d;
            STOP:    tx_d = LINE_STOP;
            default: tx_d = LINE_IDLE;
        endcase
    end

    assign tx      = tx_q;
    assign tx_busy = (state_q != IDLE);
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: frame-level model checked every cycle, plus directed literals.
// Build with UART_TX_PARITY_EN defined to exercise the parity frame.
module tb_uart_transmitter;

    localparam int C   = 4;
    localparam int C68 = 68;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_start, tx_start68;
    logic [7:0] tx_data, tx_data68;
    logic       tx, tx_busy, tx_done;
    logic       tx68, tx_busy68, tx_done68;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    uart_transmitter #(.CLKS_PER_BIT(C)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx       (tx),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    uart_transmitter #(.CLKS_PER_BIT(C68)) dut68 (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_start (tx_start68),
        .tx_data  (tx_data68),
        .tx       (tx68),
        .tx_busy  (tx_busy68),
        .tx_done  (tx_done68)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame as a bit list in send order: start, data LSB first, [parity], stop.
    function automatic logic [10:0] frame_of(input logic [7:0] d);
        logic [10:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1+i] = d[i];
`ifdef UART_TX_PARITY_EN
        f[9] = ^d;
`endif
        return f;
    endfunction

    function automatic logic fbit(input logic [10:0] f, input int k);
        logic [3:0] k4;
        k4 = k[3:0];
        return f[k4];
    endfunction

    logic        m_busy;
    logic        m_done;
    int          m_t;
    logic [10:0] m_frame;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_done  <= 1'b0;
            m_t     <= 0;
            m_frame <= '1;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (m_t + 1 == NB * C) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                end
                m_t <= m_t + 1;
            end else if (tx_start) begin
                m_busy  <= 1'b1;
                m_t     <= 0;
                m_frame <= frame_of(tx_data);
            end
        end
    end

    always @(negedge clk) begin
        check("model_tx", tx, m_busy ? fbit(m_frame, m_t / C) : 1'b1);
        check("model_busy", tx_busy, m_busy);
        check("model_done", tx_done, m_done);
        check("done_excl_busy", tx_done && tx_busy, 0);
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int a5_seq[11];
        int s55_seq[11];
        int d, k, a0, d1, d2;
`ifdef UART_TX_PARITY_EN
        a5_seq  = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
        s55_seq = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 1};
`else
        a5_seq  = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1};
        s55_seq = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 1};
`endif
        tx_start = 1'b0; tx_data = 8'h00;
        tx_start68 = 1'b0; tx_data68 = 8'h00;

        repeat (3) @(negedge clk);
        check("reset_tx", tx, 1);
        check("reset_busy", tx_busy, 0);
        check("reset_done", tx_done, 0);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 0xA5 frame with an ignored request mid-frame and data changed after acceptance
        #1 tx_start = 1'b1; tx_data = 8'hA5;
        @(posedge clk);
        #1 tx_start = 1'b0; tx_data = 8'h3C;
        for (int t = 0; t < NB * C; t++) begin
            @(negedge clk);
            if (t % C == 1) check("a5_bit", tx, a5_seq[t / C]);
            check("a5_busy", tx_busy, 1);
            if (t == 10) begin #1 tx_start = 1'b1; tx_data = 8'hFF; end
            if (t == 11) begin #1 tx_start = 1'b0; end
        end
        @(negedge clk);
        check("a5_done", tx_done, 1);
        check("a5_busy_at_done", tx_busy, 0);
        d = 0;
        repeat (NB * C + 4) begin
            @(negedge clk);
            if (tx_done) d++;
        end
        check("a5_extra_done", d, 0);

        // back-to-back frames with tx_start held high
        #1 tx_start = 1'b1; tx_data = 8'h00;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!tx_busy && k < 10);
        check("b2b_accept", tx_busy, 1);
        a0 = cyc;
        #1 tx_data = 8'h81;
        d1 = -1; d2 = -1; k = 0;
        while (d2 < 0 && k < 3 * NB * C) begin
            @(negedge clk);
            k++;
            if (tx_done) begin
                if (d1 < 0) d1 = cyc;
                else begin
                    d2 = cyc;
                    #1 tx_start = 1'b0;
                end
            end
        end
        tx_start = 1'b0;
        check("b2b_done1", d1 - a0, NB * C);
        check("b2b_done2", d2 - a0, 2 * NB * C + 1);
        repeat (NB * C + 4) @(negedge clk);

        // random requests and data
        repeat (1500) begin
            @(negedge clk);
            #1 tx_start = ($urandom_range(0, 9) == 0);
            tx_data = 8'($urandom);
        end
        #1 tx_start = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (tx_busy && k < NB * C + 4);
        check("random_drain", tx_busy, 0);

`ifdef UART_TX_PARITY_EN
        #1 tx_start = 1'b1; tx_data = 8'h07;
        @(posedge clk);
        #1 tx_start = 1'b0;
        for (int t = 0; t < NB * C; t++) begin
            @(negedge clk);
            if (t == 9 * C + 1) check("parity_bit", tx, 1);
        end
        @(negedge clk);
        check("parity_len_done", tx_done, 1);
        repeat (4) @(negedge clk);
`endif

        // reset mid-frame
        @(negedge clk);
        #1 tx_start = 1'b1; tx_data = 8'hC3;
        @(negedge clk);
        #1 tx_start = 1'b0;
        repeat (14) @(negedge clk);
        check("mid_busy", tx_busy, 1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_reset_tx", tx, 1);
        check("mid_reset_busy", tx_busy, 0);
        check("mid_reset_done", tx_done, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        d = 0;
        repeat (NB * C + 5) begin
            @(negedge clk);
            if (tx_done) d++;
        end
        check("mid_no_done", d, 0);

        // 68 clocks per bit, 0x55
        #1 tx_start68 = 1'b1; tx_data68 = 8'h55;
        @(posedge clk);
        #1 tx_start68 = 1'b0;
        for (int t = 0; t < NB * C68; t++) begin
            @(negedge clk);
            check("b68_tx", tx68, s55_seq[t / C68]);
            check("b68_busy", tx_busy68, 1);
            check("b68_done_low", tx_done68, 0);
        end
        @(negedge clk);
        check("b68_done", tx_done68, 1);
        check("b68_busy_end", tx_busy68, 0);
        check("b68_idle", tx68, 1);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
